mux_arbiter2: RTL

MUX_ARBITER2 -- requirements
Module: mux_arbiter2

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/MUX2TO1.sv | 11 +
 rtl/mux_arbiter2.sv | 85 ++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester arbitrated mux: state encoding and the default width.
package mux_arb_pkg;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] IDLE_ENC = 2'b00;
  localparam logic [1:0] G0_ENC   = 2'b01;
  localparam logic [1:0] G1_ENC   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    G0   = G0_ENC,
    G1   = G1_ENC
  } arb_st_e;
endpackage

// File: rtl/MUX2TO1.sv
// Shared-datapath 2:1 mux; sel=0 passes in0, sel=1 passes in1.
module MUX2TO1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux_arbiter2.sv
// Two-requester arbiter driving one shared 2:1 mux into a single output register.
// Optional burst locking is enabled by defining BURST_LOCK_EN (adds lock0/lock1 ports).
module mux_arbiter2
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
`ifdef BURST_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  input  logic              out_ready
);
  arb_st_e           state;
  logic              last;
  logic              slot_free;
  logic              lk0, lk1;
  logic [DATA_W-1:0] mux_out;

`ifdef BURST_LOCK_EN
  assign lk0 = lock0;
  assign lk1 = lock1;
`else
  assign lk0 = 1'b0;
  assign lk1 = 1'b0;
`endif

  assign sel       = (state == G1);
  assign slot_free = !out_valid || out_ready;
  assign gnt0      = (state == G0) && req0 && slot_free;
  assign gnt1      = (state == G1) && req1 && slot_free;

  MUX2TO1 #(.W(DATA_W)) u_mux (
    .in0 (data0),
    .in1 (data1),
    .sel (sel),
    .out (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        out_data  <= mux_out;
        out_valid <= 1'b1;
        last      <= gnt1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A stalled Gx (req held, slot busy) simply stays put.
      case (state)
        IDLE: begin
          if (req0 && req1) state <= last ? G0 : G1;
          else if (req0)    state <= G0;
          else if (req1)    state <= G1;
        end
        G0: begin
          if (!req0)                     state <= IDLE;
          else if (gnt0 && req1 && !lk0) state <= G1;
        end
        G1: begin
          if (!req1)                     state <= IDLE;
          else if (gnt1 && req0 && !lk1) state <= G0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
